// File: rtl/ice_fm_rx_period.sv
// FM receive period meter: synchronises the FM line, times rising-edge to
// rising-edge in system clocks, and reports per-period and block-average results.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_ACQ  | no reference edge yet; the next rising edge starts a measurement
// ST_MEAS | timing since the last accepted edge; report, reject glitch or time out

module ice_fm_rx_period #(
    parameter int WIDTH      = 16,
    parameter int AVG_LOG2   = 3,
    parameter int MIN_PERIOD = 4,
    parameter int TIMEOUT    = 60000
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_fm,
    output logic [WIDTH-1:0] o_period,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_avg,
    output logic             o_avg_valid,
    output logic             o_timeout
);

    localparam int AW = WIDTH + AVG_LOG2;

    localparam logic [WIDTH-1:0]    CNT_MAX = '1;
    localparam logic [WIDTH-1:0]    CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0]    MIN_P   = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0]    TO_LAST = WIDTH'(TIMEOUT - 1);
    localparam logic [AVG_LOG2-1:0] N_LAST  = '1;

    typedef enum logic {
        ST_ACQ  = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AVG_LOG2-1:0] n_q, n_d;
    logic [WIDTH-1:0]    period_q, period_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                timeout_q, timeout_d;

    logic                rise;
    logic                edge_ok;
    logic [AW-1:0]       acc_sum;

    assign rise    = sync2_q & ~prev_q;
    assign edge_ok = rise && (cnt_q >= MIN_P);
    assign acc_sum = acc_q + AW'(cnt_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        acc_d       = acc_q;
        n_d         = n_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            ST_ACQ: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_MEAS;
                end
            end
            ST_MEAS: begin
                // An edge landing on the timeout cycle still counts as a period.
                if (edge_ok) begin
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = CNT_ONE;
                    if (n_q == N_LAST) begin
                        avg_d       = WIDTH'(acc_sum >> AVG_LOG2);
                        avg_valid_d = 1'b1;
                        acc_d       = '0;
                        n_d         = '0;
                    end else begin
                        acc_d = acc_sum;
                        n_d   = n_q + 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    acc_d     = '0;
                    n_d       = '0;
                    state_d   = ST_ACQ;
                end
            end
            default: state_d = ST_ACQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q     <= ST_ACQ;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= i_fm;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_period    = period_q;
    assign o_valid     = valid_q;
    assign o_avg       = avg_q;
    assign o_avg_valid = avg_valid_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_ice_fm_rx_period.sv
// Bench for ice_fm_rx_period: two instances (wide and narrow counter) share one
// FM line; every cycle both are compared to a timestamp-based reference model.

module tb_ice_fm_rx_period;

    localparam int W1 = 16, L1 = 3, M1 = 4, T1 = 1000;
    localparam int W2 = 8,  L2 = 3, M2 = 4, T2 = 200;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic fm   = 1'b0;

    always #5 clk = ~clk;

    logic [W1-1:0] period1, avg1;
    logic          valid1, avg_valid1, timeout1;
    logic [W2-1:0] period2, avg2;
    logic          valid2, avg_valid2, timeout2;

    ice_fm_rx_period #(.WIDTH(W1), .AVG_LOG2(L1), .MIN_PERIOD(M1), .TIMEOUT(T1)) u_dut1 (
        .i_clk(clk), .i_nrst(nrst), .i_fm(fm),
        .o_period(period1), .o_valid(valid1), .o_avg(avg1),
        .o_avg_valid(avg_valid1), .o_timeout(timeout1)
    );

    ice_fm_rx_period #(.WIDTH(W2), .AVG_LOG2(L2), .MIN_PERIOD(M2), .TIMEOUT(T2)) u_dut2 (
        .i_clk(clk), .i_nrst(nrst), .i_fm(fm),
        .o_period(period2), .o_valid(valid2), .o_avg(avg2),
        .o_avg_valid(avg_valid2), .o_timeout(timeout2)
    );

    int nchk = 0, npass = 0, nfail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: periods are distances between detection timestamps;
    // a block is just a running sum and a sample count.
    int     p_min[2] = '{M1, M2};
    int     p_to[2]  = '{T1, T2};
    int     p_log[2] = '{L1, L2};
    bit     armed[2];
    int     last_edge[2];
    longint blk_sum[2];
    int     blk_n[2];
    int     e_period[2], e_avg[2];
    bit     e_valid[2], e_avg_valid[2], e_timeout[2];
    bit     smp[$];
    int     cyc = 0;

    task automatic model_step(input int u, input bit rst_ok, input bit det, input int q);
        int el;
        e_valid[u]     = 1'b0;
        e_avg_valid[u] = 1'b0;
        if (!rst_ok) begin
            armed[u] = 0; blk_sum[u] = 0; blk_n[u] = 0;
            e_period[u] = 0; e_avg[u] = 0; e_timeout[u] = 0;
        end else if (!armed[u]) begin
            if (det) begin
                armed[u] = 1;
                last_edge[u] = q;
            end
        end else begin
            el = q - last_edge[u];
            if (det && el >= p_min[u]) begin
                e_period[u] = el; e_valid[u] = 1; e_timeout[u] = 0;
                last_edge[u] = q;
                blk_sum[u] += el;
                blk_n[u]++;
                if (blk_n[u] == (1 << p_log[u])) begin
                    e_avg[u] = int'(blk_sum[u] >> p_log[u]);
                    e_avg_valid[u] = 1;
                    blk_sum[u] = 0; blk_n[u] = 0;
                end
            end else if (el >= p_to[u] - 1) begin
                e_timeout[u] = 1; e_period[u] = 0;
                armed[u] = 0; blk_sum[u] = 0; blk_n[u] = 0;
            end
        end
    endtask

    int vcnt1 = 0, vcnt2 = 0, avcnt1 = 0;
    int t_valid1 = 0, t_to1 = 0;
    bit to1_prev = 0;

    always @(posedge clk) begin
        bit fm_s, rst_ok, det;
        fm_s   = fm;
        rst_ok = nrst;
        det    = (cyc >= 3) && smp[cyc-2] && !smp[cyc-3];
        for (int u = 0; u < 2; u++) model_step(u, rst_ok, det, cyc - 1);
        // Reset clears the whole synchroniser history seen by the detector.
        if (!rst_ok) begin
            smp.push_back(1'b0);
            if (cyc >= 1) smp[cyc-1] = 1'b0;
            if (cyc >= 2) smp[cyc-2] = 1'b0;
        end else begin
            smp.push_back(fm_s);
        end
        #1;
        check_eq("dut1_outputs", {period1, valid1, avg1, avg_valid1, timeout1},
                 {16'(e_period[0]), e_valid[0], 16'(e_avg[0]), e_avg_valid[0], e_timeout[0]});
        check_eq("dut2_outputs", {period2, valid2, avg2, avg_valid2, timeout2},
                 {8'(e_period[1]), e_valid[1], 8'(e_avg[1]), e_avg_valid[1], e_timeout[1]});
        if (valid1) begin vcnt1++; t_valid1 = cyc; end
        if (valid2) vcnt2++;
        if (avg_valid1) avcnt1++;
        if (timeout1 && !to1_prev) t_to1 = cyc;
        to1_prev = timeout1;
        cyc++;
    end

    bit rnd_rst = 0;

    task automatic cyc_drive(input bit f, input bit r);
        @(negedge clk);
        fm   = f;
        nrst = r;
    endtask

    task automatic drive_period(input int p, input int hi);
        for (int i = 0; i < p; i++)
            cyc_drive(i < hi, !(rnd_rst && $urandom_range(0, 399) == 0));
    endtask

    task automatic drive_glitch_period();
        for (int i = 0; i < 120; i++) cyc_drive(i == 0 || i == 2, 1'b1);
    endtask

    int snap_v, snap_v2, snap_av;
    int p, hi;

    initial begin
        repeat (3) cyc_drive(1'b0, 1'b0);
        check_eq("reset_state", {period1, valid1, avg1, avg_valid1, timeout1}, 64'd0);

        // steady 120-clock tone
        snap_v = vcnt1;
        repeat (14) drive_period(120, 60);
        check_eq("steady_valid_count", vcnt1 - snap_v, 13);
        check_eq("steady_period", period1, 120);
        check_eq("steady_avg", avg1, 120);

        // reset mid-block, then alternating 100/141
        cyc_drive(1'b0, 1'b0);
        cyc_drive(1'b0, 1'b1);
        check_eq("reset_mid_outputs", {period1, valid1, avg1, avg_valid1, timeout1}, 64'd0);
        snap_v = vcnt1; snap_av = avcnt1;
        for (int i = 0; i < 8; i++) drive_period((i % 2) ? 141 : 100, 50);
        drive_period(120, 60);
        check_eq("alt_valid_count", vcnt1 - snap_v, 8);
        check_eq("alt_avg_count", avcnt1 - snap_av, 1);
        check_eq("alt_avg_trunc", avg1, 120);
        check_eq("alt_last_period", period1, 141);

        // glitch rejection
        snap_v = vcnt1;
        repeat (10) drive_glitch_period();
        check_eq("glitch_valid_count", vcnt1 - snap_v, 10);
        check_eq("glitch_period", period1, 120);

        // carrier loss and restart
        repeat (T1 + 20) cyc_drive(1'b0, 1'b1);
        check_eq("loss_timeout", timeout1, 1);
        check_eq("loss_period", period1, 0);
        check_eq("loss_avg_hold", avg1, 120);
        check_eq("loss_latency", t_to1 - t_valid1, T1 - 1);
        snap_v = vcnt1;
        drive_period(120, 60);
        check_eq("restart_first_edge", vcnt1 - snap_v, 0);
        check_eq("restart_timeout_held", timeout1, 1);
        drive_period(120, 60);
        check_eq("restart_second_edge", vcnt1 - snap_v, 1);
        check_eq("restart_period", period1, 120);
        check_eq("restart_timeout_clr", timeout1, 0);

        // narrow instance: period above its timeout is never reported
        repeat (300) cyc_drive(1'b0, 1'b1);
        snap_v2 = vcnt2;
        repeat (6) drive_period(210, 105);
        check_eq("sat_no_valid", vcnt2 - snap_v2, 0);
        check_eq("sat_timeout", timeout2, 1);
        check_eq("sat_period", period2, 0);
        check_eq("sat_wide_period", period1, 210);

        // boundary periods around MIN_PERIOD and the narrow timeout
        drive_period(120, 60); drive_period(120, 60);
        drive_period(4, 2); drive_period(3, 1); drive_period(5, 2);
        drive_period(198, 99); drive_period(200, 100); drive_period(120, 60);

        // randomized periods, gaps and resets
        rnd_rst = 1;
        for (int i = 0; i < 80; i++) begin
            p = $urandom_range(2, 260);
            if ($urandom_range(0, 15) == 0) p = $urandom_range(900, 1100);
            if (p == T2 - 1 || p == T1 - 1) p = p + 2;
            hi = $urandom_range(1, p - 1);
            drive_period(p, hi);
        end
        rnd_rst = 0;
        repeat (10) cyc_drive(1'b0, 1'b1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
